// File: rtl/crossing_pkg.sv
// rtl/crossing_pkg.sv - shared state codes, lamp codes and widths for the crossing sequencer
package crossing_pkg;

  localparam int PCNT_W = 4;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_RED    = 2'd3
  } state_t;

  localparam logic [2:0] LED_OFF = 3'b000;
  localparam logic [2:0] LED_G   = 3'b001;
  localparam logic [2:0] LED_Y   = 3'b010;
  localparam logic [2:0] LED_R   = 3'b100;

  function automatic logic [2:0] led_code(input state_t s);
    case (s)
      ST_GREEN:  return LED_G;
      ST_YELLOW: return LED_Y;
      ST_RED:    return LED_R;
      default:   return LED_OFF;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - phase tick enable, one clk cycle high every TICK_DIV cycles
module tick_gen #(
  parameter int TICK_DIV = 13500000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/crossing_ctrl.sv
// rtl/crossing_ctrl.sv - pedestrian crossing sequencer: walk button debounce, lamp FSM
module crossing_ctrl
  import crossing_pkg::*;
#(
  parameter int TICK_DIV  = 13500000,
  parameter int DEB_CYC   = 16,
  parameter int GREEN_MIN = 2,
  parameter int GREEN_MAX = 4,
  parameter int YELLOW_T  = 1,
  parameter int RED_T     = 7,
  parameter int WALK_T    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb0,
  output logic [2:0] LED,
  output logic       LED3,
  output logic       req_pend,
  output logic [1:0] phase
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam logic [DW-1:0]     DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [PCNT_W-1:0] GMIN_1   = PCNT_W'(GREEN_MIN - 1);
  localparam logic [PCNT_W-1:0] GMAX_1   = PCNT_W'(GREEN_MAX - 1);
  localparam logic [PCNT_W-1:0] YEL_1    = PCNT_W'(YELLOW_T - 1);
  localparam logic [PCNT_W-1:0] RED_1    = PCNT_W'(RED_T - 1);
  localparam logic [PCNT_W-1:0] WALK_C   = PCNT_W'(WALK_T);

  logic tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic          pb_s1, pb_s2, pb_db, pb_db_q;
  logic [DW-1:0] deb_cnt;

  // The debounced level only flips after DEB_CYC consecutive samples that disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pb_s1   <= 1'b0;
      pb_s2   <= 1'b0;
      pb_db   <= 1'b0;
      pb_db_q <= 1'b0;
      deb_cnt <= '0;
    end else begin
      pb_s1   <= pb0;
      pb_s2   <= pb_s1;
      pb_db_q <= pb_db;
      if (pb_s2 == pb_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        pb_db   <= pb_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  state_t            state, state_n;
  logic [PCNT_W-1:0] pcnt, pcnt_n;
  logic              serving, serving_n, req_n;
  logic              press, red_entry, req_any;

  assign press = pb_db & ~pb_db_q & ~LED3;

  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    if (tick) begin
      pcnt_n = pcnt + 1'b1;
      case (state)
        ST_INIT:   state_n = ST_GREEN;
        ST_GREEN:  if ((req_pend && pcnt >= GMIN_1) || pcnt == GMAX_1) state_n = ST_YELLOW;
        ST_YELLOW: if (pcnt == YEL_1) state_n = ST_RED;
        ST_RED:    if (pcnt == RED_1) state_n = ST_GREEN;
        default:   state_n = ST_INIT;
      endcase
      if (state_n != state) pcnt_n = '0;
    end
  end

  // A request is consumed by the Red it arrives in front of, including one landing on the entry edge.
  always_comb begin
    red_entry = (state_n == ST_RED) && (state != ST_RED);
    req_any   = req_pend | press;
    req_n     = red_entry ? 1'b0 : req_any;
    if (red_entry) begin
      serving_n = req_any;
    end else if (state_n == ST_RED) begin
      serving_n = serving;
    end else begin
      serving_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      pcnt     <= '0;
      serving  <= 1'b0;
      req_pend <= 1'b0;
      LED      <= LED_OFF;
      LED3     <= 1'b0;
      phase    <= 2'd0;
    end else begin
      state    <= state_n;
      pcnt     <= pcnt_n;
      serving  <= serving_n;
      req_pend <= req_n;
      LED      <= led_code(state_n);
      LED3     <= (state_n == ST_RED) && serving_n && (pcnt_n < WALK_C);
      phase    <= state_n;
    end
  end

endmodule

// File: tb/tb_crossing_ctrl.sv
// tb/tb_crossing_ctrl.sv - bench for crossing_ctrl against a tick-level behavioural model
module tb_crossing_ctrl;

  localparam int TD = 4, DC = 3, GMIN = 2, GMAX = 4, YT = 1, RT = 7, WT = 5;
  localparam int CYCLE_TICKS = GMAX + YT + RT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pb0 = 1'b0;
  logic [2:0] LED;
  logic       LED3, req_pend;
  logic [1:0] phase;

  crossing_ctrl #(
    .TICK_DIV(TD), .DEB_CYC(DC), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
    .YELLOW_T(YT), .RED_T(RT), .WALK_T(WT)
  ) dut (
    .clk(clk), .rst(rst), .pb0(pb0), .LED(LED), .LED3(LED3),
    .req_pend(req_pend), .phase(phase)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase number, ticks spent in phase, request/serve flags, debounced level and press history.
  int k, m_ph, m_el;
  bit m_req, m_serve, m_db, m_rise;
  bit hist[$];

  function automatic bit m_walk();
    return (m_ph == 3) && m_serve && (m_el < WT);
  endfunction

  function automatic logic [2:0] lamp(input int ph);
    return (ph == 0) ? 3'b000 : 3'(1 << (ph - 1));
  endfunction

  function automatic logic [2:0] nominal_led(input int kk);
    int c;
    if (kk < TD) return 3'b000;
    c = (kk / TD - 1) % CYCLE_TICKS;
    if (c < GMAX) return 3'b001;
    if (c < GMAX + YT) return 3'b010;
    return 3'b100;
  endfunction

  task automatic model_reset();
    k = 0; m_ph = 0; m_el = 0;
    m_req = 0; m_serve = 0; m_db = 0; m_rise = 0;
    hist.delete();
    repeat (2 + DC) hist.push_back(1'b0);
  endtask

  task automatic model_edge(input bit pb);
    bit tick, press, flip, enter_red;
    int n, nph;
    k++;
    tick  = (k % TD == 0);
    press = m_rise && !m_walk();
    hist.push_back(pb);
    // the level seen by the debouncer at this edge is the button sampled two edges earlier
    flip = 1;
    for (int i = 0; i < DC; i++)
      if (hist[hist.size() - 3 - i] == m_db) flip = 0;
    m_rise = 0;
    if (flip) begin
      m_db   = !m_db;
      m_rise = m_db;
    end
    nph = m_ph;
    if (tick) begin
      n = m_el + 1;
      case (m_ph)
        0: nph = 1;
        1: if (n == GMAX || (m_req && n >= GMIN)) nph = 2;
        2: if (n == YT) nph = 3;
        default: if (n == RT) nph = 1;
      endcase
      m_el = (nph != m_ph) ? 0 : n;
    end
    enter_red = (nph == 3) && (m_ph != 3);
    if (enter_red) begin
      m_serve = m_req | press;
      m_req   = 0;
    end else begin
      if (nph != 3) m_serve = 0;
      m_req = m_req | press;
    end
    m_ph = nph;
    while (hist.size() > 16) void'(hist.pop_front());
  endtask

  task automatic step();
    logic [6:0] e;
    @(posedge clk);
    model_edge(pb0);
    #1;
    e = {2'(m_ph), m_req, m_walk(), lamp(m_ph)};
    check("cyc", 32'({phase, req_pend, LED3, LED}), 32'(e));
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  int guard, cnt, red_cyc, walk_cyc;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", 32'({phase, req_pend, LED3, LED}), 32'd0);
    release_reset();

    // free-running cycle with no requests against the closed-form schedule
    for (int i = 0; i < 150; i++) begin
      step();
      check("nominal", 32'(LED), 32'(nominal_led(k)));
    end

    // early Green exit on a request pressed at the start of Green
    guard = 0;
    do begin step(); guard++; end while (!(m_ph == 1 && m_el == 0 && k % TD == 0) && guard < 200);
    check("wait_green", 32'(guard < 200), 32'd1);
    cnt = 0;
    while (LED == 3'b001 && cnt < 100) begin
      pb0 = 1'b1;
      step();
      cnt++;
      if (cnt == 5) check("req_early", 32'(req_pend), 32'd0);
      if (cnt == 6) check("req_lat", 32'(req_pend), 32'd1);
    end
    check("green_short", 32'(cnt), 32'(GMIN * TD));
    repeat (2) step();
    pb0 = 1'b0;
    guard = 0;
    while (LED != 3'b100 && guard < 50) begin step(); guard++; end
    check("red_entry_walk", 32'(LED3), 32'd1);
    check("red_entry_req", 32'(req_pend), 32'd0);

    // a press during the walk is ignored; measure walk and Red lengths
    red_cyc = 0; walk_cyc = 0;
    while (LED == 3'b100 && red_cyc < 100) begin
      red_cyc++;
      walk_cyc += int'(LED3);
      pb0 = (red_cyc <= 10);
      step();
    end
    pb0 = 1'b0;
    check("red_len", 32'(red_cyc), 32'(RT * TD));
    check("walk_len", 32'(walk_cyc), 32'(WT * TD));
    check("walk_press_ignored", 32'(req_pend), 32'd0);
    cnt = 0;
    while (LED == 3'b001 && cnt < 100) begin step(); cnt++; end
    check("green_full", 32'(cnt), 32'(GMAX * TD));

    // bounce pulses shorter than the debounce window
    for (int i = 0; i < 20; i++) begin
      pb0 = 1'b1;
      repeat ($urandom_range(1, 2)) step();
      pb0 = 1'b0;
      repeat (2) step();
    end
    check("bounce", 32'(req_pend), 32'd0);

    // request that latches during Yellow is served at the next Red
    guard = 0;
    do begin step(); guard++; end while (!(m_ph == 1 && m_el == GMAX - 1 && k % TD == 0) && guard < 200);
    check("wait_late_green", 32'(guard < 200), 32'd1);
    pb0 = 1'b1;
    repeat (10) step();
    pb0 = 1'b0;
    guard = 0;
    while (LED != 3'b100 && guard < 50) begin step(); guard++; end
    check("yellow_req_served", 32'(LED3), 32'd1);

    // asynchronous reset in the middle of the walk
    #2 rst = 1'b1;
    #1;
    check("rst_mid_walk", 32'({phase, req_pend, LED3, LED}), 32'd0);
    repeat (3) @(posedge clk);
    release_reset();
    for (int i = 0; i < 60; i++) begin
      step();
      check("restart", 32'(LED), 32'(nominal_led(k)));
    end

    // randomized button traffic
    for (int seg = 0; seg < 60; seg++) begin
      case ($urandom_range(0, 3))
        0: begin pb0 = 1'b0; repeat ($urandom_range(20, 60)) step(); end
        1: begin pb0 = 1'b1; repeat ($urandom_range(4, 15)) step(); pb0 = 1'b0; step(); end
        2: for (int j = 0; j < 8; j++) begin pb0 = ~pb0; repeat ($urandom_range(1, 3)) step(); end
        default: repeat (30) begin pb0 = 1'($urandom_range(0, 1)); step(); end
      endcase
    end
    pb0 = 1'b0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
